// File: rtl/dual_dac_stream_joiner.sv
// Joins paired signed A/B samples into offset-binary 32-bit DAC words,
// paced to a programmable update rate and buffered in a show-ahead FIFO.
module dual_dac_stream_joiner #(
  parameter int IN_WIDTH   = 17,
  parameter int FIFO_DEPTH = 4,
  parameter int RATE_DIV   = 1
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [IN_WIDTH-1:0] s_axis_a_tdata,
  input  logic                s_axis_a_tvalid,
  output logic                s_axis_a_tready,
  input  logic [IN_WIDTH-1:0] s_axis_b_tdata,
  input  logic                s_axis_b_tvalid,
  output logic                s_axis_b_tready,
  output logic [31:0]         m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic [15:0]         sat_a_count,
  output logic [15:0]         sat_b_count,
  input  logic                sat_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(RATE_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);

  // Returns {clamped, offset_binary_code}.
  function automatic logic [16:0] conv(input logic [IN_WIDTH-1:0] v);
    logic signed [31:0] s;
    s = {{(32 - IN_WIDTH){v[IN_WIDTH-1]}}, v};
    if (s > 32'sd32767)
      conv = {1'b1, 16'hFFFF};
    else if (s < -32'sd32768)
      conv = {1'b1, 16'h0000};
    else
      conv = {1'b0, ~v[15], v[14:0]};
  endfunction

  logic [DW-1:0] div_cnt;
  logic          pending;
  logic          tick;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          full;
  logic          empty;
  logic          join_en;
  logic          pop;
  logic [16:0]   conv_a;
  logic [16:0]   conv_b;
  logic [31:0]   mem [FIFO_DEPTH];

  assign tick    = (div_cnt == DIV_LAST);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign join_en = s_axis_a_tvalid & s_axis_b_tvalid & pending & ~full;
  assign pop     = ~empty & m_axis_tready;

  assign s_axis_a_tready = s_axis_b_tvalid & pending & ~full;
  assign s_axis_b_tready = s_axis_a_tvalid & pending & ~full;

  assign conv_a = conv(s_axis_a_tdata);
  assign conv_b = conv(s_axis_b_tdata);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      div_cnt <= '0;
      pending <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DIV_ONE;
      // A tick coinciding with a join re-arms, so no update slot is lost.
      if (tick)
        pending <= 1'b1;
      else if (join_en)
        pending <= 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (join_en)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge aclk) begin
    if (join_en)
      mem[wr_ptr[AW-1:0]] <= {conv_a[15:0], conv_b[15:0]};
  end

  // Storage is not reset, so gate the head to keep the output at zero when idle.
  assign m_axis_tvalid = ~empty;
  assign m_axis_tdata  = empty ? 32'h0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sat_a_count <= '0;
      sat_b_count <= '0;
    end else if (sat_clr) begin
      sat_a_count <= '0;
      sat_b_count <= '0;
    end else begin
      if (join_en && conv_a[16] && (sat_a_count != 16'hFFFF))
        sat_a_count <= sat_a_count + 16'd1;
      if (join_en && conv_b[16] && (sat_b_count != 16'hFFFF))
        sat_b_count <= sat_b_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_dual_dac_stream_joiner.sv
// Bench for dual_dac_stream_joiner: vector table plus scoreboard of expected
// output words, with a second instance exercising rate pacing.
module tb_dual_dac_stream_joiner;

  logic        aclk;
  logic        aresetn;
  logic [16:0] a_data, b_data;
  logic        a_valid, b_valid, a_ready, b_ready;
  logic [31:0] m_data;
  logic        m_valid, m_ready;
  logic [15:0] sat_a, sat_b;
  logic        sat_clr;

  logic [16:0] a4_data, b4_data;
  logic        a4_valid, b4_valid, a4_ready, b4_ready;
  logic [31:0] m4_data;
  logic        m4_valid, m4_ready;
  logic [15:0] sat_a4, sat_b4;
  logic        sat_clr4;

  int pass_cnt = 0;
  int total_cnt = 0;
  int join_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] q4[$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_d = '0;

  dual_dac_stream_joiner #(.IN_WIDTH(17), .FIFO_DEPTH(4), .RATE_DIV(1)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_a_tdata(a_data), .s_axis_a_tvalid(a_valid), .s_axis_a_tready(a_ready),
    .s_axis_b_tdata(b_data), .s_axis_b_tvalid(b_valid), .s_axis_b_tready(b_ready),
    .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
    .sat_a_count(sat_a), .sat_b_count(sat_b), .sat_clr(sat_clr)
  );

  dual_dac_stream_joiner #(.IN_WIDTH(17), .FIFO_DEPTH(4), .RATE_DIV(4)) dut4 (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_a_tdata(a4_data), .s_axis_a_tvalid(a4_valid), .s_axis_a_tready(a4_ready),
    .s_axis_b_tdata(b4_data), .s_axis_b_tvalid(b4_valid), .s_axis_b_tready(b4_ready),
    .m_axis_tdata(m4_data), .m_axis_tvalid(m4_valid), .m_axis_tready(m4_ready),
    .sat_a_count(sat_a4), .sat_b_count(sat_b4), .sat_clr(sat_clr4)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [15:0] ref_conv(input logic [16:0] v);
    int s;
    s = {{15{v[16]}}, v};
    if (s > 32767) return 16'hFFFF;
    if (s < -32768) return 16'h0000;
    return 16'(s + 32768);
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Scoreboard monitor for the unpaced instance.
  always @(negedge aclk) begin
    if (!aresetn) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (a_valid && a_ready && b_valid && b_ready) begin
        exp_q.push_back({ref_conv(a_data), ref_conv(b_data)});
        join_cnt++;
      end
      if (a_valid && !b_valid) chk("lone_a_ready", 32'(a_ready), 32'd0);
      if (b_valid && !a_valid) chk("lone_b_ready", 32'(b_ready), 32'd0);
      if (prev_stall && m_valid) chk("hold_data", m_data, prev_d);
      if (m_valid && m_ready) begin
        chk("sb_word_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("sb_order", m_data, exp_q.pop_front());
      end
      prev_stall = m_valid & ~m_ready;
      prev_d = m_data;
    end
  end

  typedef struct {
    logic [16:0] a;
    logic [16:0] b;
    logic [31:0] word;
    logic [15:0] sa;
    logic [15:0] sb;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic hs;
    int k, first, last, joins, idx, j0;

    tbl[0] = '{17'h00000, 17'h1FFFF, 32'h8000_7FFF, 16'd0, 16'd0};
    tbl[1] = '{17'h08000, 17'h10000, 32'hFFFF_0000, 16'd1, 16'd1};
    tbl[2] = '{17'h07FFF, 17'h18000, 32'hFFFF_0000, 16'd1, 16'd1};
    tbl[3] = '{17'h0FFFF, 17'h00001, 32'hFFFF_8001, 16'd2, 16'd1};
    tbl[4] = '{17'h1FFFE, 17'h17FFF, 32'h7FFE_0000, 16'd2, 16'd2};
    tbl[5] = '{17'h00123, 17'h18001, 32'h8123_0001, 16'd2, 16'd2};

    aresetn = 1'b0;
    a_data = '0; b_data = '0; a_valid = 0; b_valid = 0; m_ready = 1; sat_clr = 0;
    a4_data = '0; b4_data = '0; a4_valid = 1; b4_valid = 1; m4_ready = 1; sat_clr4 = 0;
    repeat (3) tick();

    chk("rst_tvalid", 32'(m_valid), 32'd0);
    chk("rst_tdata", m_data, 32'd0);
    chk("rst_treadies", 32'({a4_ready, b4_ready}), 32'd0);
    chk("rst_sat", {sat_a, sat_b}, 32'd0);
    chk("rst_tvalid4", 32'(m4_valid), 32'd0);

    // Paced instance: both channels always valid, sink always ready.
    k = 1;
    a4_data = 17'(k); b4_data = 17'(-k);
    aresetn = 1'b1;
    first = -1; last = -1; joins = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge aclk);
      hs = a4_valid & a4_ready & b4_valid & b4_ready;
      if (hs) begin
        q4.push_back({ref_conv(a4_data), ref_conv(b4_data)});
        if (first < 0) first = c;
        else chk("rate_gap", 32'(c - last), 32'd4);
        last = c;
        if (c < first + 32) joins++;
      end
      if (m4_valid && m4_ready) begin
        chk("q4_word_expected", 32'(q4.size() != 0), 32'd1);
        if (q4.size() != 0) chk("q4_order", m4_data, q4.pop_front());
      end
      tick();
      if (hs) begin
        k++;
        a4_data = 17'(k); b4_data = 17'(-k);
      end
    end
    a4_valid = 0; b4_valid = 0;
    chk("first_join_cycle", 32'(first), 32'd4);
    chk("joins_in_32", 32'(joins), 32'd8);
    chk("q4_drained", 32'(q4.size()), 32'd0);

    // Vector table: one join per entry, output one cycle later.
    foreach (tbl[i]) begin
      a_data = tbl[i].a; b_data = tbl[i].b; a_valid = 1; b_valid = 1;
      @(negedge aclk);
      chk("tbl_ready", 32'({a_ready, b_ready}), 32'd3);
      tick();
      a_valid = 0; b_valid = 0;
      chk("tbl_tvalid", 32'(m_valid), 32'd1);
      chk("tbl_word", m_data, tbl[i].word);
      chk("tbl_sat_a", 32'(sat_a), 32'(tbl[i].sa));
      chk("tbl_sat_b", 32'(sat_b), 32'(tbl[i].sb));
      tick();
    end

    sat_clr = 1; tick(); sat_clr = 0;
    chk("clr_sat", {sat_a, sat_b}, 32'd0);

    // Clear wins over a simultaneous saturating join.
    a_data = 17'h08000; b_data = 17'h10000; a_valid = 1; b_valid = 1; sat_clr = 1;
    tick();
    a_valid = 0; b_valid = 0; sat_clr = 0;
    chk("clr_priority", {sat_a, sat_b}, 32'd0);
    tick();

    // Lone A for 10 cycles, then B arrives.
    j0 = join_cnt;
    a_data = 17'h00555; a_valid = 1;
    repeat (10) begin
      @(negedge aclk);
      chk("lone_no_out", 32'(m_valid), 32'd0);
      tick();
    end
    chk("lone_no_join", 32'(join_cnt), 32'(j0));
    b_data = 17'h1FAAA; b_valid = 1;
    @(negedge aclk);
    chk("pair_a_ready", 32'(a_ready), 32'd1);
    tick();
    a_valid = 0; b_valid = 0;
    chk("pair_single_join", 32'(join_cnt), 32'(j0 + 1));
    chk("pair_word", m_data, 32'h8555_7AAA);
    tick();

    // FIFO fill with stalled sink, then drain.
    m_ready = 0; idx = 0;
    a_data = 17'(100); b_data = 17'(200); a_valid = 1; b_valid = 1;
    for (int c = 0; c < 8; c++) begin
      @(negedge aclk);
      hs = a_valid & a_ready & b_valid & b_ready;
      tick();
      if (hs) begin
        idx++;
        a_data = 17'(100 + idx); b_data = 17'(200 + idx);
      end
    end
    chk("full_accepted", 32'(idx), 32'd4);
    @(negedge aclk);
    chk("full_treadies", 32'({a_ready, b_ready}), 32'd0);
    chk("full_head", m_data, 32'h8064_80C8);
    tick();
    m_ready = 1;
    for (int c = 0; c < 30; c++) begin
      @(negedge aclk);
      if (c == 0) chk("full_pop_no_write", 32'(a_ready), 32'd0);
      hs = a_valid & a_ready & b_valid & b_ready;
      tick();
      if (hs) begin
        idx++;
        a_data = 17'(100 + idx); b_data = 17'(200 + idx);
      end
      if (idx == 6) begin a_valid = 0; b_valid = 0; end
      if (idx == 6 && !m_valid) break;
    end
    chk("drain_accepted", 32'(idx), 32'd6);
    chk("drain_empty", 32'(m_valid), 32'd0);

    // Reset with buffered, stalled words.
    m_ready = 0;
    a_data = 17'h00010; b_data = 17'h00020; a_valid = 1; b_valid = 1;
    repeat (3) tick();
    a_valid = 0; b_valid = 0;
    chk("pre_rst_tvalid", 32'(m_valid), 32'd1);
    #2 aresetn = 0;
    #1;
    chk("rst_mid_tvalid", 32'(m_valid), 32'd0);
    chk("rst_mid_tdata", m_data, 32'd0);
    tick();
    aresetn = 1; m_ready = 1;
    repeat (10) begin
      @(negedge aclk);
      chk("post_rst_no_stale", 32'(m_valid), 32'd0);
    end
    tick();
    j0 = join_cnt;
    a_data = 17'h00001; b_data = 17'h00002; a_valid = 1; b_valid = 1;
    for (int c = 0; c < 5 && join_cnt == j0; c++) tick();
    a_valid = 0; b_valid = 0;
    chk("post_rst_join", 32'(join_cnt), 32'(j0 + 1));
    repeat (3) tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
